// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one pipelined multiplier among N_REQ requesters.
// A {valid, id} tag pipeline matches the multiplier depth so each product returns with its requester ID.
module mul_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int STAGES = 2,
    parameter int IA_W   = 16,
    parameter int IB_W   = 16,
    localparam int MUL_W = IA_W + IB_W,
    localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int CNT_W = $clog2(STAGES + 2)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ*IA_W-1:0] i_req_a,
    input  logic [N_REQ*IB_W-1:0] i_req_b,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic [IA_W-1:0]       o_mul_a,
    output logic [IB_W-1:0]       o_mul_b,
    output logic                  o_mul_en,
    input  logic [MUL_W-1:0]      i_mul_prod,
    output logic                  o_res_valid,
    output logic [IDX_W-1:0]      o_res_id,
    output logic [MUL_W-1:0]      o_res_prod,
    input  logic                  i_res_ready,
    output logic [CNT_W-1:0]      o_inflight
);
    logic [IDX_W-1:0]   ptr;
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic               head_vld;
    logic [IDX_W-1:0]   head_id;
    logic               stall;
    logic               issue_vld;
    logic               op_vld;
    logic [CNT_W-1:0]   inflight;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Rotate the valids so position 0 is the requester the pointer favours.
    assign req_dbl = {i_req_valid, i_req_valid};
    assign req_rot = N_REQ'(req_dbl >> ptr);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_vld && req_rot[k]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(ptr, k);
            end
        end
    end

    assign stall     = head_vld & ~i_res_ready;
    assign issue_vld = grant_vld & ~stall & ~i_flush & i_rstn;
    assign o_mul_en  = ~stall;

    // With no pipeline the operands must stay visible while the result waits for ready.
    assign op_vld      = (STAGES == 0) ? head_vld : issue_vld;
    assign o_req_ready = issue_vld ? (N_REQ'(1) << grant_idx) : '0;
    assign o_mul_a     = op_vld ? i_req_a[grant_idx*IA_W +: IA_W] : '0;
    assign o_mul_b     = op_vld ? i_req_b[grant_idx*IB_W +: IB_W] : '0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr <= '0;
        end else if (issue_vld) begin
            ptr <= wrap_add(grant_idx, 1);
        end
    end

    generate
        if (STAGES > 0) begin : g_pipe
            logic [STAGES-1:0] tag_vld;
            logic [STAGES-1:0] vld_nxt;
            logic [IDX_W-1:0]  tag_id [STAGES];

            always_comb begin
                vld_nxt = tag_vld;
                if (i_flush) begin
                    vld_nxt = '0;
                end else if (!stall) begin
                    vld_nxt[0] = issue_vld;
                    for (int i = 1; i < STAGES; i++) vld_nxt[i] = tag_vld[i-1];
                end
            end

            // o_inflight is the popcount of the valids being loaded, so it tracks the pipe exactly.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    tag_vld  <= '0;
                    inflight <= '0;
                end else begin
                    tag_vld  <= vld_nxt;
                    inflight <= CNT_W'($countones(vld_nxt));
                end
            end

            always_ff @(posedge i_clk) begin
                if (!stall) begin
                    tag_id[0] <= grant_idx;
                    for (int i = 1; i < STAGES; i++) tag_id[i] <= tag_id[i-1];
                end
            end

            assign head_vld = tag_vld[STAGES-1];
            assign head_id  = tag_id[STAGES-1];
        end else begin : g_comb
            assign head_vld = grant_vld & ~i_flush & i_rstn;
            assign head_id  = grant_idx;
            assign inflight = '0;
        end
    endgenerate

    assign o_res_valid = head_vld;
    assign o_res_id    = head_id;
    assign o_res_prod  = i_mul_prod;
    assign o_inflight  = inflight;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: randomized traffic against a queue-based reference model (STAGES=2)
// and a STAGES=0 instance for the purely combinational path.
`timescale 1ns/1ps
module tb_mul_share_arbiter;
    localparam int N   = 4;
    localparam int STG = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [15:0] mul_a, mul_b;
    logic        mul_en;
    logic [31:0] mul_prod;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [31:0] res_prod;
    logic        res_ready;
    logic [1:0]  inflight;

    logic [3:0]  z_req_valid;
    logic [63:0] z_req_a, z_req_b;
    logic [3:0]  z_req_ready;
    logic [15:0] z_mul_a, z_mul_b;
    logic        z_mul_en;
    logic [31:0] z_mul_prod;
    logic        z_res_valid;
    logic [1:0]  z_res_id;
    logic [31:0] z_res_prod;
    logic        z_res_ready;
    logic        z_inflight;
    logic        z_flush;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.N_REQ(N), .STAGES(STG), .IA_W(16), .IB_W(16)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_req_valid(req_valid),
        .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(req_ready), .o_mul_a(mul_a),
        .o_mul_b(mul_b), .o_mul_en(mul_en), .i_mul_prod(mul_prod), .o_res_valid(res_valid),
        .o_res_id(res_id), .o_res_prod(res_prod), .i_res_ready(res_ready), .o_inflight(inflight)
    );

    mul_share_arbiter #(.N_REQ(N), .STAGES(0), .IA_W(16), .IB_W(16)) dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(z_flush), .i_req_valid(z_req_valid),
        .i_req_a(z_req_a), .i_req_b(z_req_b), .o_req_ready(z_req_ready), .o_mul_a(z_mul_a),
        .o_mul_b(z_mul_b), .o_mul_en(z_mul_en), .i_mul_prod(z_mul_prod),
        .o_res_valid(z_res_valid), .o_res_id(z_res_id), .o_res_prod(z_res_prod),
        .i_res_ready(z_res_ready), .o_inflight(z_inflight)
    );

    // Stand-in two-stage signed multiplier with a flop enable.
    logic signed [31:0] mp0, mp1;
    always @(posedge clk) begin
        if (mul_en) begin
            mp0 <= $signed(mul_a) * $signed(mul_b);
            mp1 <= mp0;
        end
    end
    assign mul_prod   = mp1;
    assign z_mul_prod = $signed(z_mul_a) * $signed(z_mul_b);

    // Reference model: FIFO of in-flight products, each with cycles left until it reaches the result port.
    typedef struct {
        logic [1:0]  id;
        logic [31:0] prod;
        int          wait_c;
    } item_t;
    item_t q[$];
    int ptr_m = 0;

    logic        e_res_valid, e_stall, e_en, e_grant;
    logic [1:0]  e_id, e_inflight;
    logic [31:0] e_prod;
    logic [3:0]  e_ready;
    logic [15:0] e_a, e_b;
    int          e_g;

    function automatic void model_eval();
        e_res_valid = (q.size() > 0) && (q[0].wait_c == 0);
        e_id        = e_res_valid ? q[0].id : 2'd0;
        e_prod      = e_res_valid ? q[0].prod : 32'd0;
        e_stall     = e_res_valid && !res_ready;
        e_en        = !e_stall;
        e_grant     = 1'b0;
        e_g         = 0;
        if (!e_stall && !flush) begin
            for (int k = 0; k < N; k++) begin
                if (!e_grant && req_valid[(ptr_m + k) % N]) begin
                    e_grant = 1'b1;
                    e_g     = (ptr_m + k) % N;
                end
            end
        end
        e_ready    = e_grant ? 4'(1 << e_g) : 4'b0;
        e_a        = e_grant ? req_a[e_g*16 +: 16] : 16'h0;
        e_b        = e_grant ? req_b[e_g*16 +: 16] : 16'h0;
        e_inflight = 2'(q.size());
    endfunction

    function automatic void model_advance();
        item_t it;
        logic signed [31:0] p;
        if (flush) begin
            q.delete();
            return;
        end
        if (e_stall) return;
        if (e_res_valid) void'(q.pop_front());
        foreach (q[i]) if (q[i].wait_c > 0) q[i].wait_c--;
        if (e_grant) begin
            p         = $signed(e_a) * $signed(e_b);
            it.id     = 2'(e_g);
            it.prod   = p;
            it.wait_c = STG - 1;
            q.push_back(it);
            ptr_m = (e_g + 1) % N;
        end
    endfunction

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            req_a[k*16 +: 16] = 16'($urandom);
            req_b[k*16 +: 16] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        req_valid   = 4'($urandom);
        z_req_valid = 4'b1111;
        rand_ops();
        #3;
        n_checks++;
        if ({req_ready, res_valid, mul_en, mul_a, mul_b, inflight} !== {4'b0, 1'b0, 1'b1, 32'h0, 2'b0}) begin
            n_fail++;
            $display("FAIL reset: ready=%b vld=%b en=%b a=%h b=%h infl=%0d, want 0000/0/1/0/0/0",
                     req_ready, res_valid, mul_en, mul_a, mul_b, inflight);
        end
        n_checks++;
        if ({z_req_ready, z_res_valid, z_mul_en, z_inflight} !== {4'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_s0: ready=%b vld=%b en=%b infl=%0d, want 0000/0/1/0",
                     z_req_ready, z_res_valid, z_mul_en, z_inflight);
        end
        repeat (2) @(posedge clk);
        req_valid   = 4'b0;
        z_req_valid = 4'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req_a[16 +: 16] = 16'd3;
        req_b[16 +: 16] = 16'd5;
        res_ready       = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 0) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            model_eval();
            n_checks++;
            if ({req_ready, res_valid, mul_en, inflight, mul_a, mul_b} !==
                {e_ready, e_res_valid, e_en, e_inflight, e_a, e_b}) begin
                n_fail++;
                $display("FAIL single c%0d: rdy=%b vld=%b en=%b infl=%0d, want %b %b %b %0d",
                         c, req_ready, res_valid, mul_en, inflight, e_ready, e_res_valid, e_en, e_inflight);
            end
            if (c == 0) begin
                n_checks++;
                if (req_ready !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL single_grant: ready=%b, want 0010", req_ready);
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({res_valid, res_id, res_prod} !== {1'b1, 2'd1, 32'd15}) begin
                    n_fail++;
                    $display("FAIL single_result: vld=%b id=%0d prod=%0d, want 1/1/15",
                             res_valid, res_id, res_prod);
                end
            end
            @(posedge clk);
            model_advance();
            #1;
        end
    endtask

    task automatic test_round_robin();
        res_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            req_valid = (c < 12) ? 4'b1111 : 4'b0000;
            rand_ops();
            @(negedge clk);
            model_eval();
            n_checks++;
            if ({req_ready, res_valid, mul_en, inflight, mul_a, mul_b} !==
                {e_ready, e_res_valid, e_en, e_inflight, e_a, e_b}) begin
                n_fail++;
                $display("FAIL rr c%0d: rdy=%b vld=%b en=%b infl=%0d, want %b %b %b %0d",
                         c, req_ready, res_valid, mul_en, inflight, e_ready, e_res_valid, e_en, e_inflight);
            end
            if (e_res_valid) begin
                n_checks++;
                if ({res_id, res_prod} !== {e_id, e_prod}) begin
                    n_fail++;
                    $display("FAIL rr_res c%0d: id=%0d prod=%h, want id=%0d prod=%h",
                             c, res_id, res_prod, e_id, e_prod);
                end
            end
            @(posedge clk);
            model_advance();
            #1;
        end
    endtask

    task automatic test_backpressure();
        int en_low = 0;
        for (int c = 0; c < 16; c++) begin
            req_valid = (c < 10) ? 4'b0101 : 4'b0000;
            res_ready = !(c >= 4 && c <= 6);
            rand_ops();
            @(negedge clk);
            model_eval();
            if (!mul_en && req_ready == 4'b0) en_low++;
            n_checks++;
            if ({req_ready, res_valid, mul_en, inflight, mul_a, mul_b} !==
                {e_ready, e_res_valid, e_en, e_inflight, e_a, e_b}) begin
                n_fail++;
                $display("FAIL bp c%0d: rdy=%b vld=%b en=%b infl=%0d, want %b %b %b %0d",
                         c, req_ready, res_valid, mul_en, inflight, e_ready, e_res_valid, e_en, e_inflight);
            end
            if (e_res_valid) begin
                n_checks++;
                if ({res_id, res_prod} !== {e_id, e_prod}) begin
                    n_fail++;
                    $display("FAIL bp_res c%0d: id=%0d prod=%h, want id=%0d prod=%h",
                             c, res_id, res_prod, e_id, e_prod);
                end
            end
            @(posedge clk);
            model_advance();
            #1;
        end
        n_checks++;
        if (en_low != 3) begin
            n_fail++;
            $display("FAIL bp_stall_len: stalled cycles=%0d, want 3", en_low);
        end
    endtask

    task automatic test_flush();
        int ptr_before = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            flush     = (c == 2);
            req_valid = (c < 3) ? 4'b0101 : ((c == 6) ? 4'b1111 : 4'b0000);
            rand_ops();
            @(negedge clk);
            model_eval();
            if (c == 2) ptr_before = ptr_m;
            n_checks++;
            if ({req_ready, res_valid, mul_en, inflight, mul_a, mul_b} !==
                {e_ready, e_res_valid, e_en, e_inflight, e_a, e_b}) begin
                n_fail++;
                $display("FAIL flush c%0d: rdy=%b vld=%b en=%b infl=%0d, want %b %b %b %0d",
                         c, req_ready, res_valid, mul_en, inflight, e_ready, e_res_valid, e_en, e_inflight);
            end
            if (c == 3) begin
                n_checks++;
                if ({res_valid, inflight} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL flush_clear: vld=%b infl=%0d, want 0/0", res_valid, inflight);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (req_ready !== 4'(1 << ptr_before)) begin
                    n_fail++;
                    $display("FAIL flush_ptr: ready=%b, want %b", req_ready, 4'(1 << ptr_before));
                end
            end
            @(posedge clk);
            model_advance();
            #1;
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req_valid = 4'($urandom);
            res_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(31) == 0);
            rand_ops();
            @(negedge clk);
            model_eval();
            n_checks++;
            if ({req_ready, res_valid, mul_en, inflight, mul_a, mul_b} !==
                {e_ready, e_res_valid, e_en, e_inflight, e_a, e_b}) begin
                n_fail++;
                $display("FAIL rand c%0d: rdy=%b vld=%b en=%b infl=%0d, want %b %b %b %0d",
                         c, req_ready, res_valid, mul_en, inflight, e_ready, e_res_valid, e_en, e_inflight);
            end
            if (e_res_valid) begin
                n_checks++;
                if ({res_id, res_prod} !== {e_id, e_prod}) begin
                    n_fail++;
                    $display("FAIL rand_res c%0d: id=%0d prod=%h, want id=%0d prod=%h",
                             c, res_id, res_prod, e_id, e_prod);
                end
            end
            @(posedge clk);
            model_advance();
            #1;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1111;
            rand_ops();
            @(negedge clk);
            model_eval();
            @(posedge clk);
            model_advance();
            #1;
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, res_valid, mul_en, mul_a, mul_b, inflight} !== {4'b0, 1'b0, 1'b1, 32'h0, 2'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b vld=%b en=%b a=%h b=%h infl=%0d, want 0000/0/1/0/0/0",
                     req_ready, res_valid, mul_en, mul_a, mul_b, inflight);
        end
        q.delete();
        ptr_m = 0;
        @(posedge clk);
        req_valid = 4'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            req_valid = 4'b1010;
            rand_ops();
            @(negedge clk);
            model_eval();
            if (c == 0) begin
                n_checks++;
                if (req_ready !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL reset_first_grant: ready=%b, want 0010", req_ready);
                end
            end
            n_checks++;
            if ({req_ready, res_valid, mul_en, inflight} !== {e_ready, e_res_valid, e_en, e_inflight}) begin
                n_fail++;
                $display("FAIL post_reset c%0d: rdy=%b vld=%b en=%b infl=%0d, want %b %b %b %0d",
                         c, req_ready, res_valid, mul_en, inflight, e_ready, e_res_valid, e_en, e_inflight);
            end
            if (e_res_valid) begin
                n_checks++;
                if ({res_id, res_prod} !== {e_id, e_prod}) begin
                    n_fail++;
                    $display("FAIL post_reset_res c%0d: id=%0d prod=%h, want id=%0d prod=%h",
                             c, res_id, res_prod, e_id, e_prod);
                end
            end
            @(posedge clk);
            model_advance();
            #1;
        end
        req_valid = 4'b0;
    endtask

    task automatic test_zero_stage();
        logic signed [15:0] a, b;
        logic signed [31:0] p;
        int r;
        z_req_valid         = 4'b1000;
        z_req_a[48 +: 16]   = 16'hFFFE;
        z_req_b[48 +: 16]   = 16'd7;
        z_res_ready         = 1'b0;
        #1;
        n_checks++;
        if ({z_res_valid, z_res_id, z_res_prod, z_req_ready, z_mul_en} !==
            {1'b1, 2'd3, 32'hFFFF_FFF2, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL s0_stall: vld=%b id=%0d prod=%h rdy=%b en=%b, want 1/3/fffffff2/0000/0",
                     z_res_valid, z_res_id, z_res_prod, z_req_ready, z_mul_en);
        end
        z_res_ready = 1'b1;
        #1;
        n_checks++;
        if ({z_res_valid, z_res_id, z_res_prod, z_req_ready, z_mul_en} !==
            {1'b1, 2'd3, 32'hFFFF_FFF2, 4'b1000, 1'b1}) begin
            n_fail++;
            $display("FAIL s0_go: vld=%b id=%0d prod=%h rdy=%b en=%b, want 1/3/fffffff2/1000/1",
                     z_res_valid, z_res_id, z_res_prod, z_req_ready, z_mul_en);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 8; c++) begin
            r = $urandom_range(3);
            a = 16'($urandom);
            b = 16'($urandom);
            p = a * b;
            z_req_valid = 4'(1 << r);
            z_req_a[r*16 +: 16] = a;
            z_req_b[r*16 +: 16] = b;
            @(negedge clk);
            n_checks++;
            if ({z_res_valid, z_res_id, z_res_prod, z_req_ready, z_inflight} !==
                {1'b1, 2'(r), p, 4'(1 << r), 1'b0}) begin
                n_fail++;
                $display("FAIL s0_rand c%0d: vld=%b id=%0d prod=%h rdy=%b, want 1/%0d/%h/%b",
                         c, z_res_valid, z_res_id, z_res_prod, z_req_ready, r, p, 4'(1 << r));
            end
            @(posedge clk);
            #1;
        end
        z_req_valid = 4'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flush       = 1'b0;
        res_ready   = 1'b1;
        req_a       = '0;
        req_b       = '0;
        z_flush     = 1'b0;
        z_res_ready = 1'b1;
        z_req_a     = '0;
        z_req_b     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        test_zero_stage();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
